// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the pipeline front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/Add_Sub_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : Add_Sub_32bit
//  Description : 32-bit adder/subtractor, i_sel=0 adds, i_sel=1 subtracts.
//  Revision    : 1.0 - initial release
// ============================================================================
module Add_Sub_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_sel,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + (i_b ^ {32{i_sel}}) + {31'd0, i_sel};

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : PC register, one-outstanding imem fetch FSM and IF/ID slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_inst,
    output logic        o_if_valid
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         r_drop;
    logic         w_drop_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_hold_inst;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_inst;
    logic         r_if_valid;

    logic         w_accept;
    logic         w_req;
    logic         w_issue;
    logic         w_load_resp;
    logic         w_load_hold;
    logic         w_capture;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;

    assign w_target = i_pc_target & 32'hFFFF_FFFC;

    Add_Sub_32bit u_pc_inc (
        .i_a   (r_pc),
        .i_b   (32'd4),
        .i_sel (1'b0),
        .o_sum (w_pc_plus4)
    );

    assign w_accept = !r_if_valid || !i_stall;
    // Back-to-back issue is allowed in S_WAIT only once the returning word has a home.
    assign w_req    = !i_pc_sel && ((r_state == S_REQ) ||
                      ((r_state == S_WAIT) && i_imem_rvalid && (r_drop || w_accept)));
    assign w_issue  = w_req && i_imem_ready;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_if_pc     = r_if_pc;
    assign o_if_inst   = r_if_inst;
    assign o_if_valid  = r_if_valid;

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_load_resp  = 1'b0;
        w_load_hold  = 1'b0;
        w_capture    = 1'b0;
        if (i_pc_sel) begin
            // A redirect with the request still in flight must discard its late response.
            if (r_state == S_WAIT && !i_imem_rvalid) begin
                w_drop_next = 1'b1;
            end else begin
                w_drop_next  = 1'b0;
                w_state_next = S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_issue) w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_drop) begin
                            w_drop_next  = 1'b0;
                            w_state_next = w_issue ? S_WAIT : S_REQ;
                        end else if (w_accept) begin
                            w_load_resp  = 1'b1;
                            w_state_next = w_issue ? S_WAIT : S_REQ;
                        end else begin
                            w_capture    = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        w_load_hold  = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= 32'd0;
            r_hold_pc   <= 32'd0;
            r_hold_inst <= 32'd0;
            r_if_pc     <= 32'd0;
            r_if_inst   <= NOP_INST;
            r_if_valid  <= 1'b0;
        end else begin
            if (i_pc_sel) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc     <= w_pc_plus4;
                r_req_pc <= r_pc;
            end

            if (w_capture) begin
                r_hold_pc   <= r_req_pc;
                r_hold_inst <= i_imem_rdata;
            end

            if (i_pc_sel) begin
                r_if_valid <= 1'b0;
                r_if_inst  <= NOP_INST;
            end else if (w_load_resp) begin
                r_if_pc    <= r_req_pc;
                r_if_inst  <= i_imem_rdata;
                r_if_valid <= 1'b1;
            end else if (w_load_hold) begin
                r_if_pc    <= r_hold_pc;
                r_if_inst  <= r_hold_inst;
                r_if_valid <= 1'b1;
            end else if (r_if_valid && !i_stall) begin
                r_if_valid <= 1'b0;
                r_if_inst  <= NOP_INST;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed bench for fetch_stage with imem responder and
//                retire scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_DMARK = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic        i_stall;
    logic        i_pc_sel;
    logic [31:0] i_pc_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_inst;
    logic        o_if_valid;

    int          n_cmp;
    int          n_err;
    int          lat;
    logic [31:0] exp_q[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_stall       (i_stall),
        .i_pc_sel      (i_pc_sel),
        .i_pc_target   (i_pc_target),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_pc       (o_if_pc),
        .o_if_inst     (o_if_inst),
        .o_if_valid    (o_if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: rdata = 0x1000_0000 | addr, delivered lat cycles late.
    initial begin
        logic        iss_seen;
        logic [31:0] iss_addr;
        logic [31:0] pend_addr;
        logic        busy;
        int          cnt;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'd0;
        busy          = 1'b0;
        cnt           = 0;
        pend_addr     = 32'd0;
        forever begin
            @(negedge clk);
            iss_seen = rst_n && o_imem_req && i_imem_ready;
            iss_addr = o_imem_addr;
            @(posedge clk);
            #1;
            i_imem_rvalid = 1'b0;
            if (iss_seen) begin
                busy      = 1'b1;
                cnt       = lat;
                pend_addr = iss_addr;
            end
            if (busy) begin
                if (cnt == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = c_DMARK | pend_addr;
                    busy          = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Retire monitor: decode consumes the slot when valid, not stalled, not redirected.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_if_valid && !i_stall && !i_pc_sel) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL retire_unexpected: got pc %h expected none", o_if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_pc", o_if_pc, e);
                    chk("retire_inst", o_if_inst, c_DMARK | e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        lat          = 0;
        rst_n        = 1'b0;
        i_stall      = 1'b0;
        i_pc_sel     = 1'b0;
        i_pc_target  = 32'd0;
        i_imem_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h100, 32'h104,
                  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

        repeat (2) step();
        @(negedge clk);
        chk("rst_valid", {31'd0, o_if_valid}, 32'd0);
        chk("rst_pc", o_if_pc, 32'd0);
        chk("rst_inst", o_if_inst, c_NOP);
        chk("rst_addr", o_imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, o_imem_req}, 32'd1);

        // Zero-wait streaming
        step(); @(negedge clk);
        chk("e1_addr", o_imem_addr, 32'h4);
        chk("e1_valid", {31'd0, o_if_valid}, 32'd0);
        step(); @(negedge clk);
        chk("e2_valid", {31'd0, o_if_valid}, 32'd1);
        chk("e2_pc", o_if_pc, 32'h0);
        step(); @(negedge clk);
        chk("e3_pc", o_if_pc, 32'h4);

        // Stall three cycles with 0x8 in IF/ID
        step(); i_stall = 1'b1; @(negedge clk);
        chk("stall1_pc", o_if_pc, 32'h8);
        chk("stall1_req", {31'd0, o_imem_req}, 32'd0);
        step(); @(negedge clk);
        chk("stall2_pc", o_if_pc, 32'h8);
        chk("stall2_req", {31'd0, o_imem_req}, 32'd0);
        step(); @(negedge clk);
        chk("stall3_pc", o_if_pc, 32'h8);
        chk("stall3_req", {31'd0, o_imem_req}, 32'd0);
        step(); i_stall = 1'b0; lat = 3; @(negedge clk);
        chk("unstall_pc", o_if_pc, 32'h8);
        step(); @(negedge clk);
        chk("hold_pc", o_if_pc, 32'hC);
        step(); @(negedge clk);
        chk("fetch10_valid", {31'd0, o_if_valid}, 32'd0);

        // Redirect while 0x10 is outstanding
        step(); i_pc_sel = 1'b1; i_pc_target = 32'h100; @(negedge clk);
        chk("redir_req", {31'd0, o_imem_req}, 32'd0);
        step(); i_pc_sel = 1'b0; lat = 0; @(negedge clk);
        chk("drop_wait_req", {31'd0, o_imem_req}, 32'd0);
        chk("drop_wait_valid", {31'd0, o_if_valid}, 32'd0);
        step(); @(negedge clk);
        chk("after_drop_addr", o_imem_addr, 32'h100);
        chk("after_drop_req", {31'd0, o_imem_req}, 32'd1);
        chk("after_drop_valid", {31'd0, o_if_valid}, 32'd0);
        step(); @(negedge clk);
        chk("tgt_inflight_valid", {31'd0, o_if_valid}, 32'd0);
        step(); @(negedge clk);
        chk("tgt_pc", o_if_pc, 32'h100);

        // Redirect and stall together, misaligned target
        step(); i_stall = 1'b1; i_pc_sel = 1'b1; i_pc_target = 32'h0000_0103;
        @(negedge clk);
        chk("rs_req", {31'd0, o_imem_req}, 32'd0);
        chk("rs_pc", o_if_pc, 32'h104);
        step(); i_stall = 1'b0; i_pc_sel = 1'b0; @(negedge clk);
        chk("rs_valid", {31'd0, o_if_valid}, 32'd0);
        chk("rs_addr", o_imem_addr, 32'h100);
        step(); step(); i_imem_ready = 1'b0;
        repeat (4) step();

        // PC wrap
        i_pc_sel = 1'b1; i_pc_target = 32'hFFFF_FFF8; @(negedge clk);
        chk("wrap_redir_req", {31'd0, o_imem_req}, 32'd0);
        step(); i_pc_sel = 1'b0; i_imem_ready = 1'b1; @(negedge clk);
        chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("wrap_addr1", o_imem_addr, 32'hFFFF_FFFC);
        step(); i_imem_ready = 1'b0; @(negedge clk);
        chk("wrap_addr2", o_imem_addr, 32'h0);
        repeat (4) step();

        // Reset in S_WAIT, then a stray rvalid in S_REQ
        lat = 3; i_imem_ready = 1'b1;
        step(); i_imem_ready = 1'b0;
        step(); #2; rst_n = 1'b0; #1;
        chk("arst_addr", o_imem_addr, 32'h0);
        chk("arst_valid", {31'd0, o_if_valid}, 32'd0);
        chk("arst_inst", o_if_inst, c_NOP);
        step(); rst_n = 1'b1; lat = 0; @(negedge clk);
        chk("rel_req", {31'd0, o_imem_req}, 32'd1);
        step(); @(negedge clk);
        chk("stray_seen", {31'd0, i_imem_rvalid}, 32'd1);
        chk("stray_valid0", {31'd0, o_if_valid}, 32'd0);
        step(); @(negedge clk);
        chk("stray_valid1", {31'd0, o_if_valid}, 32'd0);
        chk("stray_addr", o_imem_addr, 32'h0);
        i_imem_ready = 1'b1;
        step(); step(); i_imem_ready = 1'b0; @(negedge clk);
        chk("post_rst_pc", o_if_pc, 32'h0);
        repeat (4) step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
